// File: rtl/seg_scan_driver.sv
// Two-digit multiplexed seven-segment scan driver.
// Divides clk into the scan phase clock s_clk and presents the digit for the
// current phase on seg. New BCD values are staged in a shadow register and
// committed to the display register only at frame starts (s_clk 1->0), so a
// frame never shows a mix of old and new digits.
module seg_scan_driver #(
  parameter int unsigned DIV   = 50000,
  parameter int unsigned CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] din,
  input  logic       blank_lz,
  output logic       s_clk,
  output logic [6:0] seg,
  output logic       ack
);

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned VAL_W   = 2 * DIGIT_W;
  localparam int unsigned SEG_W   = 7;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0]   cnt;
  logic [VAL_W-1:0]   sh;
  logic [VAL_W-1:0]   dr;
  logic               pend;
  logic               wrap;
  logic               frame_start;
  logic               xfer;
  logic [DIGIT_W-1:0] digit;
  logic               blank;

  assign wrap        = (cnt == CNT_MAX);
  assign frame_start = wrap & s_clk;
  assign xfer        = frame_start & pend;

  // Scan divider: one s_clk phase every DIV clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      s_clk <= 1'b0;
    end else if (wrap) begin
      cnt   <= '0;
      s_clk <= ~s_clk;
    end else begin
      cnt   <= cnt + CNT_W'(1);
    end
  end

  // Shadow register and pending flag; a load on a frame-start edge re-arms pend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh   <= '0;
      pend <= 1'b0;
    end else if (load) begin
      sh   <= din;
      pend <= 1'b1;
    end else if (xfer) begin
      pend <= 1'b0;
    end
  end

  // Display register commit at frame start, with a one-cycle ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dr  <= '0;
      ack <= 1'b0;
    end else begin
      ack <= xfer;
      if (xfer) begin
        dr <= sh;
      end
    end
  end

  assign digit = s_clk ? dr[VAL_W-1:DIGIT_W] : dr[DIGIT_W-1:0];
  assign blank = s_clk & blank_lz & (dr[VAL_W-1:DIGIT_W] == '0);

  // Segment decode (a..g on bit6..bit0); non-BCD codes show a dash.
  always_comb begin
    seg = SEG_W'(7'b0000001);
    unique case (digit)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b0110000;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1111011;
      default: seg = 7'b0000001;
    endcase
    if (blank) begin
      seg = '0;
    end
  end

endmodule
